mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Memory controller sitting between the core and the byte-wide unified RAM. It serializes committed stores from the reorder buffer, loads from the load/store buffer and instruction fetches from IF into 1-byte-per-cycle RAM accesses. It returns load results tagged with their ROB id on the `mem_valid`/`mem_dependency`/`mem_value` broadcast, and drives `mem_busy` back to the ROB's store-commit logic.

## Interface
- `ROB_SIZE_WIDTH`, default `` `ROB_SIZE_WIDTH `` (5): width of the ROB tag.
- `ADDR_WIDTH`, default 32: RAM address width. Upper bits pass through unchanged.
- Clocking is fixed: one clock; reset is asynchronous and active-low.
- `clk_in`  in  1  system clock.
- `rst_n_in`  in  1  asynchronous active-low reset.
- `rdy_in`  in  1  global enable; low freezes all state.
- `rob2mem_ready`  in  1  one-cycle pulse: committed store.
- `rob2mem_store_type`  in  2  encoding 0 = SB, 1 = SH, 2 = SW.
- `rob2mem_addr`  in  32  store address.
- `rob2mem_value`  in  32  store data; low bytes are used.
- `lsb2mem_ready`  in  1  load request, level, held until served or flushed.
- `lsb2mem_load_type`  in  3  encoding 0 = LB, 1 = LH, 2 = LW, 3 = LBU, 4 = LHU.
- `lsb2mem_addr`  in  32  load address.
- `lsb2mem_rob_id`  in  ROB_SIZE_WIDTH  tag of the load.
- `if2mem_ready`  in  1  fetch request, level.
- `if2mem_addr`  in  32  fetch PC.
- `need_flush_in`  in  1  misprediction flush from the ROB.
- `io_buffer_full`  in  1  UART buffer full.
- `mem_din`  in  8  RAM read data.
- `mem_busy`  out  1  a store is pending or executing.
- `mem_valid`  out  1  one-cycle load-result pulse.
- `mem_dependency`  out  ROB_SIZE_WIDTH  ROB tag of the result.
- `mem_value`  out  32  extended load data.
- `mem2if_valid`  out  1  one-cycle fetch-result pulse.
- `mem2if_instr`  out  32  fetched word.
- `mem_a`  out  ADDR_WIDTH  RAM address.
- `mem_dout`  out  8  RAM write data.
- `mem_wr`  out  1  1 = write.

## Operation
- **States:** IDLE, STORE, LOAD, FETCH. There is a 2-bit byte counter `cnt` and a 1-entry store holding register `st_pend`.
- **Store capture:** a `rob2mem_ready` pulse is always captured into `st_pend`, even outside IDLE.
- **Store ordering rule:** `mem_busy = st_pend | (state == STORE)`. The ROB never pulses while it samples `mem_busy = 1`.
- **Arbitration:** happens in IDLE only. Priority is `st_pend` > `lsb2mem_ready` > `if2mem_ready`. Arbitration latches addr, type, tag and n = byte count (1/2/4), then clears `st_pend` when that is the winner.
- **STORE:**
  - Byte k: `mem_a` = addr + k, `mem_dout` = value[8k+7:8k], `mem_wr` = 1.
  - If addr[17:16] == 2'b11 (IO space) and `io_buffer_full` = 1, hold the current byte with `mem_wr` = 0 and do not advance.
- **LOAD/FETCH:**
  - Address byte k in cycle k. `mem_din` for byte k arrives the following cycle and is shifted into assembly register bits [8k+7:8k].
  - LB and LH sign-extend bit 7 and bit 15 respectively. LBU and LHU zero-extend. FETCH is always 4 bytes.
- **Flush:** `need_flush_in` = 1 aborts LOAD and FETCH. The FSM goes to IDLE next cycle and the aborted access produces no `mem_valid`/`mem2if_valid`. STORE and `st_pend` are never aborted because stores are committed.
- **rdy_in = 0:** all registers hold and `mem_wr` is forced to 0.
- **Reset values:** every output is 0, state is IDLE, `st_pend` = 0, `cnt` = 0.

## Timing
- Let t be the IDLE cycle in which a request wins arbitration.
- **Load/fetch of n bytes:**
  - `mem_a` = addr + k with `mem_wr` = 0 in cycle t+1+k.
  - Data for byte k is sampled at the end of cycle t+2+k.
  - The result pulse is in cycle t+2+n, exactly one cycle wide. The FSM is in IDLE in that same cycle.
  - LW is therefore a 6-cycle round trip.
- **Store of n bytes:** `mem_wr` = 1 in cycles t+1 .. t+n, then IDLE in cycle t+n+1, plus any IO stall cycles.
- **Store pulse at cycle p:** `st_pend` and `mem_busy` are 1 from p+1. If IDLE at p+1, the store wins at p+1. `mem_busy` drops in the IDLE cycle after the last byte.
- **Simultaneous store pulse and winning load:** the load proceeds and the store waits in `st_pend`. It wins the next IDLE cycle ahead of any load or fetch.
- **Flush in the same cycle as the result pulse:** the pulse is still emitted; the consumer discards it.

## Structure
- **Shared constants in `const_param.v`:**
  - `` `LOAD_TYPE_NUM_WIDTH `` and the load-type codes.
  - `` `STORE_TYPE_NUM_WIDTH `` and the store-type codes, shared with the ROB.
  - The IO address prefix.
- **State encodings:** localparams.
- **Sub-module:** one, `load_extend`, purely combinational. It takes the assembly register and load type and produces `mem_value`. The FSM stays in `mem_ctrl`.

## Test plan
- **Word fetch:** RAM[0x100..0x103] = 13 05 00 00; `if2mem_ready`, addr 0x100 -> `mem2if_instr` = 0x00000513 with `mem2if_valid` in cycle t+6.
- **Signed and unsigned byte load:** RAM[0x20] = 0x80. LB, tag 7 -> `mem_value` = 0xFFFFFF80 with `mem_dependency` = 7. LBU -> 0x00000080.
- **Halfword store:** SH of 0xDEADBEEF to 0x40 -> two writes, 0x40 = EF and 0x41 = BE; `mem_busy` falls in cycle t+3.
- **Store priority:** store pulse during an in-flight LW, with LW and fetch both pending -> the LW completes, the store runs next, then the fetch. `mem_busy` stays 1 from p+1 until the store finishes.
- **Flush:** `need_flush_in` at cycle t+3 of an LW -> no `mem_valid`, and the FSM returns to IDLE. The same flush during an SW -> all 4 bytes are still written.
- **IO write with async reset:** SB to 0x30000 with `io_buffer_full` = 1 for 3 cycles -> `mem_wr` = 0 for 3 cycles, then one write. `rst_n_in` low mid-LW -> all outputs 0 immediately, with no response.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: load/store type codes, IO prefix, FSM states and byte-count helpers
package mem_ctrl_pkg;
  localparam int ROB_SIZE_WIDTH_DEF = 5;
  localparam int LOAD_TYPE_NUM_WIDTH = 3;
  localparam int STORE_TYPE_NUM_WIDTH = 2;
  localparam logic [2:0] LD_LB = 3'd0;
  localparam logic [2:0] LD_LH = 3'd1;
  localparam logic [2:0] LD_LW = 3'd2;
  localparam logic [2:0] LD_LBU = 3'd3;
  localparam logic [2:0] LD_LHU = 3'd4;
  localparam logic [1:0] ST_SB = 2'd0;
  localparam logic [1:0] ST_SH = 2'd1;
  localparam logic [1:0] ST_SW = 2'd2;
  localparam logic [1:0] IO_PREFIX = 2'b11;
  typedef enum logic [1:0] {IDLE, STORE, LOAD, FETCH} state_t;
  function automatic logic [1:0] ld_last(input logic [2:0] t);
    return t == LD_LW ? 2'd3 : (t == LD_LH || t == LD_LHU) ? 2'd1 : 2'd0;
  endfunction
  function automatic logic [1:0] st_last(input logic [1:0] t);
    return t == ST_SB ? 2'd0 : t == ST_SH ? 2'd1 : 2'd3;
  endfunction
endpackage

// File: rtl/mem_ctrl_load_extend.sv
// load_extend: sign/zero-extends the assembled load bytes by load type
module load_extend
  import mem_ctrl_pkg::*;
(
  input  logic [31:0]                    raw,
  input  logic [LOAD_TYPE_NUM_WIDTH-1:0] load_type,
  output logic [31:0]                    value
);
  always_comb
    value = load_type == LD_LB  ? {{24{raw[7]}}, raw[7:0]} :
            load_type == LD_LH  ? {{16{raw[15]}}, raw[15:0]} :
            load_type == LD_LBU ? {24'h0, raw[7:0]} :
            load_type == LD_LHU ? {16'h0, raw[15:0]} : raw;
endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: serializes stores, loads and fetches into byte-wide RAM accesses
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ROB_SIZE_WIDTH = ROB_SIZE_WIDTH_DEF,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                            clk_in,
  input  logic                            rst_n_in,
  input  logic                            rdy_in,
  input  logic                            rob2mem_ready,
  input  logic [STORE_TYPE_NUM_WIDTH-1:0] rob2mem_store_type,
  input  logic [31:0]                     rob2mem_addr,
  input  logic [31:0]                     rob2mem_value,
  input  logic                            lsb2mem_ready,
  input  logic [LOAD_TYPE_NUM_WIDTH-1:0]  lsb2mem_load_type,
  input  logic [31:0]                     lsb2mem_addr,
  input  logic [ROB_SIZE_WIDTH-1:0]       lsb2mem_rob_id,
  input  logic                            if2mem_ready,
  input  logic [31:0]                     if2mem_addr,
  input  logic                            need_flush_in,
  input  logic                            io_buffer_full,
  input  logic [7:0]                      mem_din,
  output logic                            mem_busy,
  output logic                            mem_valid,
  output logic [ROB_SIZE_WIDTH-1:0]       mem_dependency,
  output logic [31:0]                     mem_value,
  output logic                            mem2if_valid,
  output logic [31:0]                     mem2if_instr,
  output logic [ADDR_WIDTH-1:0]           mem_a,
  output logic [7:0]                      mem_dout,
  output logic                            mem_wr
);
  state_t state, state_next;
  logic [1:0] cnt, last, rd_idx;
  logic issued, st_pend, stall, st_win, ld_win, if_win, finish;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0] st_addr, st_value, asm_q, asm_next, ext;
  logic [STORE_TYPE_NUM_WIDTH-1:0] st_type;
  logic [LOAD_TYPE_NUM_WIDTH-1:0] ld_type;
  logic [ROB_SIZE_WIDTH-1:0] tag;

  load_extend u_ext (.raw(asm_next), .load_type(ld_type), .value(ext));

  always_comb begin
    rd_idx = issued ? cnt : cnt - 2'd1;
    asm_next = asm_q;
    asm_next[{rd_idx, 3'b000} +: 8] = mem_din;
    stall = addr[17:16] == IO_PREFIX && io_buffer_full;
    st_win = state == IDLE && st_pend;
    ld_win = state == IDLE && !st_pend && lsb2mem_ready && !need_flush_in;
    if_win = state == IDLE && !st_pend && !lsb2mem_ready && if2mem_ready && !need_flush_in;
    finish = (state == LOAD || state == FETCH) && issued && !need_flush_in;
    state_next = state == IDLE ? (st_win ? STORE : ld_win ? LOAD : if_win ? FETCH : IDLE) :
                 state == STORE ? (!stall && cnt == last ? IDLE : STORE) :
                 need_flush_in || issued ? IDLE : state;
    mem_busy = st_pend || state == STORE;
    mem_wr = rdy_in && state == STORE && !stall;
    mem_a = state == IDLE ? '0 : addr + ADDR_WIDTH'(cnt);
    mem_dout = state == STORE ? st_value[{cnt, 3'b000} +: 8] : 8'h00;
  end

  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) state <= IDLE;
    else if (rdy_in) state <= state_next;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt <= '0;
      last <= '0;
      issued <= 1'b0;
      st_pend <= 1'b0;
      addr <= '0;
      st_addr <= '0;
      st_value <= '0;
      st_type <= '0;
      ld_type <= '0;
      tag <= '0;
      asm_q <= '0;
      mem_valid <= 1'b0;
      mem_dependency <= '0;
      mem_value <= '0;
      mem2if_valid <= 1'b0;
      mem2if_instr <= '0;
    end else if (rdy_in) begin
      if (rob2mem_ready) begin
        st_pend <= 1'b1;
        st_addr <= rob2mem_addr;
        st_value <= rob2mem_value;
        st_type <= rob2mem_store_type;
      end else if (st_win) st_pend <= 1'b0;
      if (st_win) begin
        addr <= st_addr[ADDR_WIDTH-1:0];
        last <= st_last(st_type);
      end
      if (ld_win) begin
        addr <= lsb2mem_addr[ADDR_WIDTH-1:0];
        ld_type <= lsb2mem_load_type;
        tag <= lsb2mem_rob_id;
        last <= ld_last(lsb2mem_load_type);
        asm_q <= '0;
      end
      if (if_win) begin
        addr <= if2mem_addr[ADDR_WIDTH-1:0];
        ld_type <= LD_LW;
        last <= 2'd3;
        asm_q <= '0;
      end
      if (state == STORE && !stall) cnt <= cnt == last ? 2'd0 : cnt + 2'd1;
      if (state == LOAD || state == FETCH) begin
        if (issued || cnt != 2'd0) asm_q <= asm_next;
        if (need_flush_in || issued) begin
          cnt <= 2'd0;
          issued <= 1'b0;
        end else if (cnt == last) issued <= 1'b1;
        else cnt <= cnt + 2'd1;
      end
      mem_valid <= finish && state == LOAD;
      if (finish && state == LOAD) begin
        mem_dependency <= tag;
        mem_value <= ext;
      end
      mem2if_valid <= finish && state == FETCH;
      if (finish && state == FETCH) mem2if_instr <= asm_next;
    end
  end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed self-checking bench for mem_ctrl with a 1-cycle-latency byte RAM
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;
  logic clk_in = 1'b0, rst_n_in = 1'b0, rdy_in = 1'b1;
  logic rob2mem_ready = 1'b0;
  logic [1:0] rob2mem_store_type = '0;
  logic [31:0] rob2mem_addr = '0, rob2mem_value = '0;
  logic lsb2mem_ready = 1'b0;
  logic [2:0] lsb2mem_load_type = '0;
  logic [31:0] lsb2mem_addr = '0;
  logic [4:0] lsb2mem_rob_id = '0;
  logic if2mem_ready = 1'b0;
  logic [31:0] if2mem_addr = '0;
  logic need_flush_in = 1'b0, io_buffer_full = 1'b0;
  logic [7:0] mem_din;
  logic mem_busy, mem_valid, mem2if_valid, mem_wr;
  logic [4:0] mem_dependency;
  logic [31:0] mem_value, mem2if_instr, mem_a;
  logic [7:0] mem_dout;
  logic [7:0] ram [0:262143];
  int n_chk = 0, n_pass = 0;

  mem_ctrl dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
    .rob2mem_ready(rob2mem_ready), .rob2mem_store_type(rob2mem_store_type),
    .rob2mem_addr(rob2mem_addr), .rob2mem_value(rob2mem_value),
    .lsb2mem_ready(lsb2mem_ready), .lsb2mem_load_type(lsb2mem_load_type),
    .lsb2mem_addr(lsb2mem_addr), .lsb2mem_rob_id(lsb2mem_rob_id),
    .if2mem_ready(if2mem_ready), .if2mem_addr(if2mem_addr),
    .need_flush_in(need_flush_in), .io_buffer_full(io_buffer_full), .mem_din(mem_din),
    .mem_busy(mem_busy), .mem_valid(mem_valid), .mem_dependency(mem_dependency),
    .mem_value(mem_value), .mem2if_valid(mem2if_valid), .mem2if_instr(mem2if_instr),
    .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) begin
    if (mem_wr) ram[mem_a[17:0]] <= mem_dout;
    mem_din <= ram[mem_a[17:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(negedge clk_in);
  endtask

  task automatic wait_pulse(input bit fetch, input int start, output int cyc);
    cyc = start;
    do begin
      step();
      cyc++;
    end while (!(fetch ? mem2if_valid : mem_valid) && cyc < 30);
  endtask

  task automatic do_load(input string tag, input logic [2:0] ty, input logic [31:0] a,
                         input logic [4:0] id, input logic [31:0] exp, input int lat);
    int cyc;
    lsb2mem_ready = 1'b1;
    lsb2mem_load_type = ty;
    lsb2mem_addr = a;
    lsb2mem_rob_id = id;
    wait_pulse(1'b0, 0, cyc);
    lsb2mem_ready = 1'b0;
    check({tag, "_lat"}, cyc, lat);
    check({tag, "_val"}, mem_value, exp);
    check({tag, "_dep"}, {27'h0, mem_dependency}, {27'h0, id});
  endtask

  task automatic store_pulse(input logic [1:0] ty, input logic [31:0] a, input logic [31:0] v);
    rob2mem_ready = 1'b1;
    rob2mem_store_type = ty;
    rob2mem_addr = a;
    rob2mem_value = v;
    step();
    rob2mem_ready = 1'b0;
  endtask

  initial begin
    int cyc, writes, busy_low, valids;
    ram[32'h100] = 8'h13; ram[32'h101] = 8'h05; ram[32'h102] = 8'h00; ram[32'h103] = 8'h00;
    ram[32'h20] = 8'h80; ram[32'h21] = 8'h92;
    ram[32'h60] = 8'h11; ram[32'h61] = 8'h22; ram[32'h62] = 8'h33; ram[32'h63] = 8'h44;
    step();
    step();
    check("rst_busy", mem_busy, 0);
    check("rst_valid", mem_valid, 0);
    check("rst_if_valid", mem2if_valid, 0);
    check("rst_a", mem_a, 0);
    check("rst_wr", mem_wr, 0);
    check("rst_value", mem_value, 0);
    rst_n_in = 1'b1;
    step();
    // word fetch
    if2mem_ready = 1'b1;
    if2mem_addr = 32'h100;
    step();
    check("fetch_a0", mem_a, 32'h100);
    check("fetch_wr0", mem_wr, 0);
    wait_pulse(1'b1, 1, cyc);
    if2mem_ready = 1'b0;
    check("fetch_lat", cyc, 6);
    check("fetch_instr", mem2if_instr, 32'h00000513);
    // byte and halfword loads
    do_load("lb", LD_LB, 32'h20, 5'd7, 32'hFFFFFF80, 3);
    do_load("lbu", LD_LBU, 32'h20, 5'd9, 32'h00000080, 3);
    do_load("lh", LD_LH, 32'h20, 5'd2, 32'hFFFF9280, 4);
    do_load("lhu", LD_LHU, 32'h20, 5'd4, 32'h00009280, 4);
    // halfword store
    store_pulse(ST_SH, 32'h40, 32'hDEADBEEF);
    check("sh_busy_t", mem_busy, 1);
    step();
    check("sh_wr1", mem_wr, 1);
    check("sh_a1", mem_a, 32'h40);
    check("sh_d1", mem_dout, 8'hEF);
    step();
    check("sh_wr2", mem_wr, 1);
    check("sh_a2", mem_a, 32'h41);
    check("sh_d2", mem_dout, 8'hBE);
    step();
    check("sh_busy_t3", mem_busy, 0);
    check("sh_wr3", mem_wr, 0);
    check("sh_ram", {ram[32'h41], ram[32'h40]}, 16'hBEEF);
    // store pulse during in-flight LW with fetch pending
    lsb2mem_ready = 1'b1;
    lsb2mem_load_type = LD_LW;
    lsb2mem_addr = 32'h60;
    lsb2mem_rob_id = 5'd3;
    if2mem_ready = 1'b1;
    if2mem_addr = 32'h100;
    step();
    store_pulse(ST_SW, 32'h70, 32'hCAFEF00D);
    check("prio_busy_p1", mem_busy, 1);
    wait_pulse(1'b0, 2, cyc);
    lsb2mem_ready = 1'b0;
    check("prio_lw_lat", cyc, 6);
    check("prio_lw_val", mem_value, 32'h44332211);
    check("prio_lw_dep", mem_dependency, 3);
    check("prio_busy_lw", mem_busy, 1);
    writes = 0;
    busy_low = 0;
    cyc = 0;
    do begin
      step();
      cyc++;
      if (!mem_busy && writes < 4) busy_low++;
      if (mem_wr) writes++;
    end while (!mem2if_valid && cyc < 30);
    if2mem_ready = 1'b0;
    check("prio_writes", writes, 4);
    check("prio_busy_hold", busy_low, 0);
    check("prio_fetch_lat", cyc, 11);
    check("prio_instr", mem2if_instr, 32'h00000513);
    check("prio_ram", {ram[32'h73], ram[32'h72], ram[32'h71], ram[32'h70]}, 32'hCAFEF00D);
    // flush of an LW at t+3
    lsb2mem_ready = 1'b1;
    lsb2mem_load_type = LD_LW;
    lsb2mem_addr = 32'h60;
    lsb2mem_rob_id = 5'd5;
    repeat (3) step();
    need_flush_in = 1'b1;
    lsb2mem_ready = 1'b0;
    step();
    need_flush_in = 1'b0;
    check("flush_idle", mem_a, 0);
    valids = mem_valid ? 1 : 0;
    repeat (6) begin
      step();
      if (mem_valid) valids++;
    end
    check("flush_no_valid", valids, 0);
    do_load("post_flush", LD_LB, 32'h20, 5'd6, 32'hFFFFFF80, 3);
    // flush during SW never aborts it
    store_pulse(ST_SW, 32'h80, 32'h11223344);
    writes = 0;
    step();
    if (mem_wr) writes++;
    need_flush_in = 1'b1;
    step();
    if (mem_wr) writes++;
    need_flush_in = 1'b0;
    repeat (6) begin
      step();
      if (mem_wr) writes++;
    end
    check("flush_sw_writes", writes, 4);
    check("flush_sw_ram", {ram[32'h83], ram[32'h82], ram[32'h81], ram[32'h80]}, 32'h11223344);
    // IO byte store stalled by a full UART buffer
    io_buffer_full = 1'b1;
    store_pulse(ST_SB, 32'h30000, 32'h000000A5);
    writes = 0;
    repeat (3) begin
      step();
      if (mem_wr) writes++;
    end
    check("io_stall", writes, 0);
    step();
    io_buffer_full = 1'b0;
    #1;
    check("io_wr", mem_wr, 1);
    check("io_a", mem_a, 32'h30000);
    check("io_d", mem_dout, 8'hA5);
    step();
    check("io_busy_done", mem_busy, 0);
    check("io_ram", ram[32'h30000], 8'hA5);
    // async reset in the middle of an LW
    lsb2mem_ready = 1'b1;
    lsb2mem_load_type = LD_LW;
    lsb2mem_addr = 32'h60;
    lsb2mem_rob_id = 5'd1;
    repeat (2) step();
    rst_n_in = 1'b0;
    #1;
    check("arst_a", mem_a, 0);
    check("arst_busy", mem_busy, 0);
    check("arst_valid", mem_valid, 0);
    lsb2mem_ready = 1'b0;
    repeat (2) step();
    rst_n_in = 1'b1;
    valids = 0;
    repeat (8) begin
      step();
      if (mem_valid) valids++;
    end
    check("arst_no_resp", valids, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
